// File: rtl/pulse_pkg.sv
// pulse_pkg: shared types and constants for pulse_burst_gen.
//   state_e      - controller FSM states
//   LED_*        - bit positions of the fields on the LEDR debug bus
//   DEF_*        - default widths of the period and pulse counters
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int LED_GO     = 9;
  localparam int LED_BUSY   = 8;
  localparam int LED_CNT_HI = 7;
  localparam int LED_CNT_LO = 0;

  localparam int DEF_WIDTH   = 6;
  localparam int DEF_BURST_W = 8;

endpackage

// File: rtl/pulse_burst_gen_period_counter.sv
// period_counter: free-running modulo-period counter.
//   clock, reset : clock, synchronous active-high reset
//   clr          : hold the count at zero
//   period       : modulus P (caller guarantees P >= 1 whenever clr is low)
//   tick         : high while cnt == P-1 (the cycle that wraps)
//   cnt          : current count, exported for debug display
module period_counter
  import pulse_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic [WIDTH-1:0] period,
  output logic             tick,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == period - WIDTH'(1));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q + WIDTH'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pulse_burst_gen.sv
// pulse_burst_gen: programmable-period strobe generator.
//   Continuous mode (mode=0): one-cycle go every P clocks while enabled.
//   Burst mode (mode=1): after start, exactly N go strobes, then one-cycle done.
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   enable                : master enable, dropping it aborts back to IDLE
//   mode, start           : mode select and burst request (sampled in IDLE)
//   divideby              : period P (0 behaves as 1)
//   burst_len             : burst strobe count N
//   go, busy, done        : registered strobe / run flag / end-of-burst strobe
//   LEDR                  : {go, busy, cnt[7:0]} debug bus
module pulse_burst_gen
  import pulse_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               mode,
  input  logic               start,
  input  logic [WIDTH-1:0]   divideby,
  input  logic [BURST_W-1:0] burst_len,
  output logic               go,
  output logic               busy,
  output logic               done,
  output logic [9:0]         LEDR
);

  localparam int CW = (WIDTH < 8) ? WIDTH : 8;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   period_q, period_d;
  logic [BURST_W-1:0] pulses_q, pulses_d;
  logic               mode_q, mode_d;
  logic               go_q, go_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               clr, tick;
  logic [WIDTH-1:0]   cnt;

  period_counter #(.WIDTH(WIDTH)) u_period (
    .clock  (clock),
    .reset  (reset),
    .clr    (clr),
    .period (period_q),
    .tick   (tick),
    .cnt    (cnt)
  );

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    pulses_d = pulses_q;
    mode_d   = mode_q;
    go_d     = 1'b0;
    done_d   = 1'b0;
    clr      = 1'b1;
    unique case (state_q)
      IDLE: begin
        // Period is re-sampled every idle cycle so it is valid on RUN entry.
        period_d = (divideby == '0) ? WIDTH'(1) : divideby;
        pulses_d = '0;
        if (enable && !mode) begin
          state_d = RUN;
          mode_d  = 1'b0;
        end else if (enable && mode && start) begin
          mode_d   = 1'b1;
          pulses_d = burst_len;
          state_d  = (burst_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          // Abort wins over a coincident tick: no go, no done.
          state_d  = IDLE;
          pulses_d = '0;
        end else begin
          clr  = 1'b0;
          go_d = tick;
          if (tick && mode_q) begin
            if (pulses_q == BURST_W'(1)) begin
              state_d  = DONE;
              pulses_d = '0;
            end else begin
              pulses_d = pulses_q - BURST_W'(1);
            end
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      period_q <= '0;
      pulses_q <= '0;
      mode_q   <= 1'b0;
      go_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      pulses_q <= pulses_d;
      mode_q   <= mode_d;
      go_q     <= go_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign go   = go_q;
  assign busy = busy_q;
  assign done = done_q;

  assign LEDR[LED_GO]                  = go_q;
  assign LEDR[LED_BUSY]                = busy_q;
  assign LEDR[LED_CNT_HI:LED_CNT_LO]   = 8'(cnt[CW-1:0]);

endmodule

// File: tb/tb_pulse_burst_gen.sv
module tb_pulse_burst_gen;

  logic       clock = 1'b0;
  logic       reset, enable, mode, start;
  logic [5:0] divideby;
  logic [7:0] burst_len;
  logic       go, busy, done;
  logic [9:0] LEDR;

  int n_asrt = 0;
  int n_fail = 0;
  int go_cnt = 0;
  int done_cnt = 0;

  // Reference model: tracks "edges since entering RUN" (k); go fires when
  // k is a multiple of P, cnt equals k mod P, a burst ends once k/P == N.
  int m_st;     // 0 idle, 1 run, 2 done
  int m_k, m_p, m_n;
  bit m_burst;
  bit e_go, e_busy, e_done;
  int e_cnt;

  pulse_burst_gen dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .mode      (mode),
    .start     (start),
    .divideby  (divideby),
    .burst_len (burst_len),
    .go        (go),
    .busy      (busy),
    .done      (done),
    .LEDR      (LEDR)
  );

  always #5 clock = ~clock;

  task automatic model_edge();
    e_go   = 1'b0;
    e_done = 1'b0;
    if (reset) begin
      m_st  = 0;
      m_p   = 0;
      e_cnt = 0;
    end else begin
      case (m_st)
        0: begin
          m_p   = (divideby == 0) ? 1 : int'(divideby);
          e_cnt = 0;
          if (enable && !mode) begin
            m_st = 1; m_k = 0; m_burst = 0;
          end else if (enable && mode && start) begin
            m_burst = 1; m_n = int'(burst_len); m_k = 0;
            m_st = (m_n == 0) ? 2 : 1;
          end
        end
        1: begin
          if (!enable) begin
            m_st  = 0;
            e_cnt = 0;
          end else begin
            m_k++;
            e_go  = ((m_k % m_p) == 0);
            e_cnt = m_k % m_p;
            if (m_burst && e_go && (m_k / m_p) == m_n) m_st = 2;
          end
        end
        default: begin
          e_done = 1'b1;
          m_st   = 0;
          e_cnt  = 0;
        end
      endcase
    end
    e_busy = (m_st == 1);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    logic [9:0] e_led;
    @(posedge clock);
    model_edge();
    #1;
    e_led = {e_go, e_busy, e_cnt[7:0]};
    chk("go",   32'(go),   32'(e_go));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("LEDR", 32'(LEDR), 32'(e_led));
    if (go === 1'b1) go_cnt++;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic clr_counts();
    go_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; mode = 1'b0; start = 1'b0;
    divideby = 6'd2; burst_len = 8'd0;
    run_n(2);
    chk("reset_LEDR", 32'(LEDR), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // 1: continuous, P=2
    enable = 1'b1; mode = 1'b0; divideby = 6'd2;
    cyc();
    clr_counts();
    run_n(10);
    chk("s1_go_count", 32'(go_cnt), 32'd5);
    chk("s1_done_count", 32'(done_cnt), 32'd0);
    enable = 1'b0; cyc();

    // 2: continuous, P=3, divideby change mid-run is ignored
    enable = 1'b1; divideby = 6'd3;
    cyc();
    clr_counts();
    run_n(20);
    chk("s2_go_count", 32'(go_cnt), 32'd6);
    divideby = 6'd5;
    clr_counts();
    run_n(15);
    chk("s2_frozen_period", 32'(go_cnt), 32'd5);
    enable = 1'b0; cyc();

    // 3: burst of 3, P=4, start re-asserted during RUN
    enable = 1'b1; mode = 1'b1; divideby = 6'd4; burst_len = 8'd3; start = 1'b1;
    cyc();
    start = 1'b0;
    clr_counts();
    run_n(5);
    start = 1'b1;
    run_n(2);
    start = 1'b0;
    run_n(13);
    chk("s3_go_count", 32'(go_cnt), 32'd3);
    chk("s3_done_count", 32'(done_cnt), 32'd1);
    chk("s3_busy_end", 32'(busy), 32'd0);
    enable = 1'b0; cyc();

    // 4: boundaries
    enable = 1'b1; mode = 1'b0; divideby = 6'd0;
    cyc(); clr_counts(); run_n(6);
    chk("s4_div0_go", 32'(go_cnt), 32'd6);
    enable = 1'b0; cyc();
    enable = 1'b1; divideby = 6'd1;
    cyc(); clr_counts(); run_n(6);
    chk("s4_div1_go", 32'(go_cnt), 32'd6);
    enable = 1'b0; cyc();
    enable = 1'b1; mode = 1'b1; burst_len = 8'd0; start = 1'b1; divideby = 6'd3;
    clr_counts();
    cyc();
    start = 1'b0;
    run_n(3);
    chk("s4_len0_go", 32'(go_cnt), 32'd0);
    chk("s4_len0_done", 32'(done_cnt), 32'd1);
    enable = 1'b0; cyc();
    enable = 1'b1; mode = 1'b0; divideby = 6'd63;
    cyc(); clr_counts(); run_n(130);
    chk("s4_div63_go", 32'(go_cnt), 32'd2);
    enable = 1'b0; cyc();

    // 5: abort after 2 burst pulses, then reset mid-run
    enable = 1'b1; mode = 1'b1; divideby = 6'd2; burst_len = 8'd5; start = 1'b1;
    cyc();
    start = 1'b0;
    clr_counts(); run_n(4);
    chk("s5_pre_abort_go", 32'(go_cnt), 32'd2);
    enable = 1'b0;
    clr_counts(); run_n(4);
    chk("s5_abort_done", 32'(done_cnt), 32'd0);
    chk("s5_abort_go", 32'(go_cnt), 32'd0);
    enable = 1'b1; mode = 1'b0; divideby = 6'd3;
    cyc(); run_n(4);
    reset = 1'b1;
    cyc();
    chk("s5_reset_LEDR", 32'(LEDR), 32'd0);
    chk("s5_reset_go", 32'(go), 32'd0);
    chk("s5_reset_busy", 32'(busy), 32'd0);
    reset = 1'b0; enable = 1'b0;
    cyc();

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      enable    = ($urandom_range(0, 15) != 0);
      mode      = $urandom_range(0, 1);
      start     = ($urandom_range(0, 4) == 0);
      divideby  = 6'($urandom_range(0, 7));
      burst_len = 8'($urandom_range(0, 4));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
